// File: rtl/uarc_pkg.sv
// Shared core types: program address type and reset PC.
// Reused by core0 and the prefetch stage.
package uarc_pkg;

  localparam int PROGRAM_ADDR_WIDTH = 8;

  typedef logic [PROGRAM_ADDR_WIDTH-1:0] prog_addr_t;

  localparam prog_addr_t RESET_PC = '0;

endpackage

// File: rtl/prefetch_if.sv
// Byte delivery handshake from prefetch to the decoder.
// master: out_valid/out_byte/out_pc driven, out_ready sampled.
interface prefetch_if #(
  parameter int W = 8
);

  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_byte;
  logic [W-1:0] out_pc;

  modport master (
    output out_valid,
    output out_byte,
    output out_pc,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_byte,
    input  out_pc,
    output out_ready
  );

endinterface

// File: rtl/prefetch_byte_fifo.sv
// byte_fifo: DEPTH x 8 queue with push/pop/flush.
// Ports: clk, reset, push/din, pop, flush, count, head.
module byte_fifo #(
  parameter int DEPTH_MAG = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [7:0]         din,
  input  logic               pop,
  input  logic               flush,
  output logic [DEPTH_MAG:0] count,
  output logic [7:0]         head
);

  localparam int DEPTH = 1 << DEPTH_MAG;

  localparam logic [DEPTH_MAG-1:0] PTR_ONE =
    DEPTH_MAG'(1);
  localparam logic [DEPTH_MAG:0] CNT_ONE =
    (DEPTH_MAG+1)'(1);

  logic [7:0]           mem [DEPTH];
  logic [DEPTH_MAG-1:0] head_ptr;
  logic [DEPTH_MAG-1:0] tail_ptr;

  assign head = mem[head_ptr];

  always_ff @(posedge clk) begin
    if (push && !flush && !reset) begin
      mem[tail_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        tail_ptr <= tail_ptr + PTR_ONE;
      end
      if (pop) begin
        head_ptr <= head_ptr + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/prefetch.sv
// Byte prefetch stage: streams program bytes to the decoder.
// Ports: clk, reset, programmem_*, jump*, write_*, out (prefetch_if).
// Macro PREFETCH_WRITE_SNOOP_EN: flush when a write hits the window.
module prefetch #(
  parameter int PROGRAM_ADDR_WIDTH =
    uarc_pkg::PROGRAM_ADDR_WIDTH,
  parameter int DEPTH_MAG = 2,
  parameter logic [PROGRAM_ADDR_WIDTH-1:0] RESET_PC =
    uarc_pkg::RESET_PC
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [PROGRAM_ADDR_WIDTH-1:0] programmem_addr,
  input  logic [7:0]                    programmem_read_value,
  output logic [7:0]                    programmem_write_value,
  output logic                          programmem_we,
  input  logic                          jump,
  input  logic [PROGRAM_ADDR_WIDTH-1:0] jump_addr,
  input  logic                          write_en,
  input  logic [PROGRAM_ADDR_WIDTH-1:0] write_addr,
  input  logic [7:0]                    write_value,
  prefetch_if.master                    out
);

  import uarc_pkg::*;

  localparam int W     = PROGRAM_ADDR_WIDTH;
  localparam int DEPTH = 1 << DEPTH_MAG;

  localparam logic [DEPTH_MAG:0] DEPTH_C =
    (DEPTH_MAG+1)'(DEPTH);

  logic [W-1:0]       fetch_pc;
  logic [W-1:0]       deliver_pc;
  logic [W-1:0]       deliver_nx;
  logic [W-1:0]       flush_pc;
  logic               inflight;
  logic [DEPTH_MAG:0] count;
  logic [DEPTH_MAG:0] credit;
  logic [7:0]         head;
  logic               issue;
  logic               push;
  logic               pop;
  logic               hit;
  logic               flush;

  assign programmem_we          = write_en;
  assign programmem_write_value = write_value;
  assign programmem_addr        =
    write_en ? write_addr : fetch_pc;

  // Queued plus in-flight bytes; a pop this cycle
  // does not free a slot until next cycle.
  assign credit =
    count + {{DEPTH_MAG{1'b0}}, inflight};

  assign issue =
    !write_en && !jump && (credit < DEPTH_C);

  assign pop =
    out.out_valid && out.out_ready && !jump;

  assign deliver_nx =
    pop ? deliver_pc + W'(1) : deliver_pc;

`ifdef PREFETCH_WRITE_SNOOP_EN
  // Window is [deliver_pc, fetch_pc) modulo 2^W.
  assign hit = write_en &&
    ((write_addr - deliver_pc) <
     (fetch_pc - deliver_pc));
`else
  assign hit = 1'b0;
`endif

  assign flush    = jump || hit;
  assign flush_pc = jump ? jump_addr : deliver_nx;
  assign push     = inflight && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      deliver_pc <= RESET_PC;
      inflight   <= 1'b0;
    end else if (flush) begin
      fetch_pc   <= flush_pc;
      deliver_pc <= flush_pc;
      inflight   <= 1'b0;
    end else begin
      deliver_pc <= deliver_nx;
      inflight   <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + W'(1);
      end
    end
  end

  byte_fifo #(
    .DEPTH_MAG(DEPTH_MAG)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (programmem_read_value),
    .pop   (pop),
    .flush (flush),
    .count (count),
    .head  (head)
  );

  assign out.out_valid = (count != '0);
  assign out.out_byte  = head;
  assign out.out_pc    = deliver_pc;

endmodule

// File: tb/tb_prefetch.sv
// Directed bench for prefetch with a 1-cycle-latency memory.
// Ports: drives clk/reset/jump/write, models memory, checks out.
module tb_prefetch;

  logic       clk;
  logic       reset;
  logic [7:0] programmem_addr;
  logic [7:0] programmem_read_value;
  logic [7:0] programmem_write_value;
  logic       programmem_we;
  logic       jump;
  logic [7:0] jump_addr;
  logic       write_en;
  logic [7:0] write_addr;
  logic [7:0] write_value;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];

  prefetch_if #(.W(8)) pif ();

  prefetch dut (
    .clk                    (clk),
    .reset                  (reset),
    .programmem_addr        (programmem_addr),
    .programmem_read_value  (programmem_read_value),
    .programmem_write_value (programmem_write_value),
    .programmem_we          (programmem_we),
    .jump                   (jump),
    .jump_addr              (jump_addr),
    .write_en               (write_en),
    .write_addr             (write_addr),
    .write_value            (write_value),
    .out                    (pif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (programmem_we) begin
      mem[programmem_addr] <= programmem_write_value;
    end
    programmem_read_value <= mem[programmem_addr];
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic take(
    input string      tag,
    input logic [7:0] pc,
    input logic [7:0] b
  );
    int n = 0;
    while (!pif.out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(pif.out_valid), 1);
    chk({tag, "_pc"}, 32'(pif.out_pc), 32'(pc));
    chk({tag, "_byte"}, 32'(pif.out_byte), 32'(b));
    @(negedge clk);
  endtask

  task automatic do_jump(input logic [7:0] a);
    jump      = 1'b1;
    jump_addr = a;
    @(negedge clk);
    jump = 1'b0;
    chk("jmp_addr", 32'(programmem_addr), 32'(a));
    chk("jmp_v0", 32'(pif.out_valid), 0);
    @(negedge clk);
    chk("jmp_v1", 32'(pif.out_valid), 0);
    @(negedge clk);
    chk("jmp_v2", 32'(pif.out_valid), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i + 8'h10);
    end
    reset       = 1'b1;
    jump        = 1'b0;
    jump_addr   = '0;
    write_en    = 1'b0;
    write_addr  = '0;
    write_value = '0;
    pif.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(pif.out_valid), 0);
    chk("rst_we", 32'(programmem_we), 0);
    chk("rst_addr", 32'(programmem_addr), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("lat_v1", 32'(pif.out_valid), 0);
    @(negedge clk);
    chk("lat_v2", 32'(pif.out_valid), 1);
    take("s0", 8'h00, 8'h10);
    take("s1", 8'h01, 8'h11);
    take("s2", 8'h02, 8'h12);

    chk("wr_pc3", 32'(pif.out_pc), 3);
    write_en    = 1'b1;
    write_addr  = 8'h80;
    write_value = 8'h77;
    #1;
    chk("wr_we", 32'(programmem_we), 1);
    chk("wr_addr", 32'(programmem_addr), 32'h80);
    chk("wr_data", 32'(programmem_write_value), 32'h77);
    @(negedge clk);
    write_en = 1'b0;
    #1;
    chk("wr_we_off", 32'(programmem_we), 0);
    take("w4", 8'h04, 8'h14);
    take("w5", 8'h05, 8'h15);
    take("w6", 8'h06, 8'h16);
    do_jump(8'h80);
    take("rb80", 8'h80, 8'h77);

    reset         = 1'b1;
    pif.out_ready = 1'b0;
    @(negedge clk);
    chk("mid_rst_v", 32'(pif.out_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("full_v", 32'(pif.out_valid), 1);
    chk("full_pc", 32'(pif.out_pc), 0);
    chk("full_fpc", 32'(programmem_addr), 4);
    repeat (3) @(negedge clk);
    chk("full_hold", 32'(programmem_addr), 4);
    pif.out_ready = 1'b1;
    take("f0", 8'h00, 8'h10);
    take("f1", 8'h01, 8'h11);
    take("f2", 8'h02, 8'h12);
    take("f3", 8'h03, 8'h13);
    take("f4", 8'h04, 8'h14);
    do_jump(8'h40);
    take("j40", 8'h40, 8'h50);
    take("j41", 8'h41, 8'h51);
    do_jump(8'hFE);
    take("wfe", 8'hFE, 8'h0E);
    take("wff", 8'hFF, 8'h0F);
    take("w00", 8'h00, 8'h10);
    take("w01", 8'h01, 8'h11);

    reset         = 1'b1;
    pif.out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    pif.out_ready = 1'b1;
    @(negedge clk);
    pif.out_ready = 1'b0;
    chk("sn_pc1", 32'(pif.out_pc), 1);
    write_en    = 1'b1;
    write_addr  = 8'h02;
    write_value = 8'hAA;
    @(negedge clk);
    write_en      = 1'b0;
    pif.out_ready = 1'b1;
    take("sn1", 8'h01, 8'h11);
`ifdef PREFETCH_WRITE_SNOOP_EN
    take("sn2", 8'h02, 8'hAA);
`else
    take("sn2", 8'h02, 8'h12);
`endif
    take("sn3", 8'h03, 8'h13);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
